mio_bus_responder: RTL and testbench
====================================

Name: mio_bus_responder

Overview:
- Memory/IO responder on the CPU side of the MIO bus: accepts word read/write requests from the multi-cycle datapath and returns read data with an MIO_ready handshake.
- Decodes the request address into a wait-stated external synchronous RAM, an LED/switch GPIO port, and a 32-bit free-running timer.
- Sits between the CPU core and board RAM/peripherals. The CPU stalls PC and state updates while MIO_ready is low.

Parameters:
- RAM_AW, 10, RAM word-address width; RAM occupies byte addresses 0 to 4*2^RAM_AW-1.
- RAM_LATENCY, 1, cycles from registered ram_addr to valid ram_dout; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_r  in  1  read request
- mem_w  in  1  write request
- M_addr  in  32  byte address of the request; bits [1:0] are ignored for decode
- data_out  in  32  write data from the CPU
- data2CPU  out  32  read data to the CPU, registered
- MIO_ready  out  1  transaction complete or bus idle
- ram_addr  out  RAM_AW  RAM word address, registered
- ram_din  out  32  RAM write data, registered
- ram_we  out  1  RAM write strobe, registered, one-cycle pulse
- ram_dout  in  32  RAM read data
- sw_in  in  16  switch inputs
- led_out  out  16  LED register

Behaviour:
- Address map:
  - RAM: M_addr < 4*2^RAM_AW.
  - LED/SW: 0xF000_0000. Write sets led_out = data_out[15:0]; read returns {16'h0, sw_in}.
  - TIMER: 0xF000_0004. Read returns the count; write loads data_out.
  - Anything else is unmapped: reads return 0, writes are ignored.
- Request encoding: req = mem_r | mem_w. If both are high, the access is a write and data2CPU is unchanged.
- FSM states: IDLE, WAIT, DONE.
- MIO_ready = (IDLE && !req) || DONE. This is combinational from req in IDLE.
- IDLE, accept edge with req high:
  - RAM access: register ram_addr = M_addr[RAM_AW+1:2], ram_din = data_out, ram_we = mem_w; load wcnt = RAM_LATENCY; go to WAIT.
  - Non-RAM access: perform the peripheral read/write at this edge (read value goes into data2CPU); go to DONE.
- WAIT:
  - ram_we is forced to 0 after the first WAIT cycle.
  - wcnt decrements every edge.
  - At the edge where wcnt==1: if the access is a read, data2CPU <= ram_dout; go to DONE.
- DONE: MIO_ready=1 for exactly one cycle, then IDLE.
- No request is accepted in WAIT or DONE.
- A req still high when the FSM returns to IDLE starts a new transaction, giving back-to-back accesses.
- Requester contract: hold M_addr, data_out, mem_r, mem_w stable while MIO_ready is low. The responder latches them at accept anyway.
- Latency: MIO_ready is low for 1 cycle on peripheral accesses and 1+RAM_LATENCY cycles on RAM accesses, followed by one ready cycle in DONE.
- Timer: increments by 1 every clock, wrapping 0xFFFF_FFFF to 0. On a write at the accept edge, next value = data_out, then it keeps counting. A timer read returns the value before that edge's increment.
- data2CPU holds its last read value until the next read completes.
- Reset values (asynchronous): state IDLE, data2CPU=0, led_out=0, timer=0, ram_addr=0, ram_din=0, ram_we=0, wcnt=0.
- Reset mid-transaction aborts it: no completion pulse, ram_we drops immediately, and MIO_ready follows req in IDLE.

Optional Feature:
- Macro: MIO_BUS_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit), a sticky flag with reset value 0.
  - bus_err is set at accept on an unmapped address or when M_addr[1:0]!=0. Such accesses complete as unmapped: one wait cycle, no side effects, read returns 0.
  - Address 0xF000_0008 becomes mapped: read returns {31'h0, bus_err}; any write clears bus_err. Set and clear on the same edge: set wins.
- Undefined: no bus_err port; M_addr[1:0] is ignored; 0xF000_0008 is unmapped.

Test Plan:
- Reset with req low -> MIO_ready=1, data2CPU=0, led_out=0, timer=0, ram_we=0. Assert reset during WAIT -> FSM returns to IDLE, no DONE cycle.
- RAM_LATENCY=3; write 0x0000_0010 with data 0xCAFE_F00D -> ram_we high for exactly 1 cycle with ram_addr=4, ram_din=0xCAFEF00D; MIO_ready low 4 cycles, then high 1 cycle.
- RAM read at 0x0000_0010, model returns 0x1234_5678 after 3 cycles -> data2CPU=0x12345678 in the DONE cycle; MIO_ready low 4 cycles.
- Write 0xF000_0000 with 0xFFFF_A5A5 -> led_out=0xA5A5. Then read with sw_in=0x00FF -> data2CPU=0x0000_00FF; MIO_ready low 1 cycle each.
- Write timer 0xFFFF_FFFE, then read it 2 cycles after the write's accept edge -> data2CPU=0x0000_0000 (wrap). mem_r and mem_w both high on the LED address -> treated as a write, data2CPU unchanged.
- MIO_BUS_ERR_EN: read 0x8000_0000 -> data2CPU=0, bus_err=1; read 0xF000_0008 -> 1; write 0xF000_0008 -> bus_err=0; access 0x0000_0002 -> bus_err=1.

Source files
------------

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: CPU-side MIO bus responder for wait-stated RAM, LED/SW GPIO and a timer.
// Build option MIO_BUS_ERR_EN adds a sticky bus_err flag and a status register at 0xF000_0008.
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       M_addr,
  input  logic [31:0]       data_out,
  output logic [31:0]       data2CPU,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
`ifdef MIO_BUS_ERR_EN
  ,
  output logic              bus_err
`endif
);

  localparam logic [32:0] RAM_BYTES = 33'd4 << RAM_AW;
  localparam logic [29:0] LED_WA = 30'h3C00_0000;
  localparam logic [29:0] TMR_WA = 30'h3C00_0001;
  localparam logic [2:0]  LAT_W  = 3'(RAM_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  wcnt;
  logic        rd_pend;
  logic [31:0] timer;
  logic [31:0] rd_val;

  logic req;
  logic is_rd;
  logic accept;
  logic in_ram;
  logic is_led;
  logic is_tmr;
  logic sel_ram;
  logic sel_led;
  logic sel_tmr;

  assign req    = mem_r | mem_w;
  assign is_rd  = mem_r & ~mem_w;
  assign accept = (state == S_IDLE) && req;

  assign in_ram = {1'b0, M_addr} < RAM_BYTES;
  assign is_led = M_addr[31:2] == LED_WA;
  assign is_tmr = M_addr[31:2] == TMR_WA;

`ifdef MIO_BUS_ERR_EN
  localparam logic [29:0] STS_WA = 30'h3C00_0002;

  logic misal;
  logic is_sts;
  logic sel_sts;
  logic bad;

  // misaligned accesses take the unmapped path
  assign misal   = |M_addr[1:0];
  assign is_sts  = M_addr[31:2] == STS_WA;
  assign sel_ram = !misal && in_ram;
  assign sel_led = !misal && is_led;
  assign sel_tmr = !misal && is_tmr;
  assign sel_sts = !misal && is_sts;
  assign bad     = !(sel_ram | sel_led | sel_tmr | sel_sts);
`else
  assign sel_ram = in_ram;
  assign sel_led = is_led;
  assign sel_tmr = is_tmr;
`endif

  assign MIO_ready = ((state == S_IDLE) && !req) ||
                     (state == S_DONE);

  // peripheral read mux, unmapped reads return zero
  always_comb begin
    rd_val = '0;
    if (sel_led) begin
      rd_val = {16'h0, sw_in};
    end else if (sel_tmr) begin
      rd_val = timer;
`ifdef MIO_BUS_ERR_EN
    end else if (sel_sts) begin
      rd_val = {31'h0, bus_err};
`endif
    end
  end

  // free-running timer, loadable from the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (accept && sel_tmr && mem_w) begin
      timer <= data_out;
    end else begin
      timer <= timer + 32'd1;
    end
  end

`ifdef MIO_BUS_ERR_EN
  // sticky error flag; a new error beats a clearing write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (accept) begin
      if (bad) begin
        bus_err <= 1'b1;
      end else if (sel_sts && mem_w) begin
        bus_err <= 1'b0;
      end
    end
  end
`endif

  // transaction FSM: accept in IDLE, wait out RAM latency, one-cycle DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      data2CPU <= '0;
      led_out  <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      wcnt     <= '0;
      rd_pend  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            if (sel_ram) begin
              ram_addr <= M_addr[RAM_AW+1:2];
              ram_din  <= data_out;
              ram_we   <= mem_w;
              wcnt     <= LAT_W;
              rd_pend  <= is_rd;
              state    <= S_WAIT;
            end else begin
              if (mem_w && sel_led) begin
                led_out <= data_out[15:0];
              end
              if (is_rd) begin
                data2CPU <= rd_val;
              end
              state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          ram_we <= 1'b0;
          wcnt   <= wcnt - 3'd1;
          if (wcnt == 3'd1) begin
            if (rd_pend) begin
              data2CPU <= ram_dout;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: randomized bench for mio_bus_responder with a
// transaction-level model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_mio_bus_responder;

  localparam int AW  = 10;
  localparam int LAT = 3;
  localparam logic [31:0] RAM_BYTES = 32'(4 << AW);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_r = 1'b0;
  logic          mem_w = 1'b0;
  logic [31:0]   M_addr = '0;
  logic [31:0]   data_out = '0;
  logic [15:0]   sw_in = '0;
  logic [31:0]   data2CPU;
  logic          MIO_ready;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic          ram_we;
  logic [31:0]   ram_dout;
  logic [15:0]   led_out;
`ifdef MIO_BUS_ERR_EN
  logic          bus_err;
`endif

  always #5 clk = ~clk;

  mio_bus_responder #(
    .RAM_AW     (AW),
    .RAM_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_r    (mem_r),
    .mem_w    (mem_w),
    .M_addr   (M_addr),
    .data_out (data_out),
    .data2CPU (data2CPU),
    .MIO_ready(MIO_ready),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .sw_in    (sw_in),
    .led_out  (led_out)
`ifdef MIO_BUS_ERR_EN
    ,
    .bus_err  (bus_err)
`endif
  );

  // expected RAM contents, model memory state
  logic [31:0] mem_exp [0:(1<<AW)-1];

  // board RAM: ram_dout trails ram_addr by LAT-1 register stages
  logic [31:0] dev_mem [0:(1<<AW)-1];
  logic [31:0] rp0;
  logic [31:0] rp1;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1 << AW); i++) dev_mem[i] <= mem_exp[i];
    end else if (ram_we) begin
      dev_mem[ram_addr] <= ram_din;
    end
    rp0 <= dev_mem[ram_addr];
    rp1 <= rp0;
  end
  assign ram_dout = rp1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rdy;
    logic [31:0]   d2c;
    logic [15:0]   led;
    logic          err;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
  } exp_t;

  exp_t q[$];

  // model state
  logic [31:0] m_d2c = '0;
  logic [15:0] m_led = '0;
  logic        m_err = 1'b0;
  logic [31:0] t_base = '0;
  int          t_cyc = 0;
  int          cyc = 0;

  typedef enum {K_RAM, K_LED, K_TMR, K_STS, K_UNM} kind_t;

  function automatic kind_t classify(input logic [31:0] a);
    logic [29:0] wa;
    wa = a[31:2];
`ifdef MIO_BUS_ERR_EN
    if (a[1:0] != 2'b00) return K_UNM;
    if (wa == 30'h3C00_0002) return K_STS;
`endif
    if (a < RAM_BYTES) return K_RAM;
    if (wa == 30'h3C00_0000) return K_LED;
    if (wa == 30'h3C00_0001) return K_TMR;
    return K_UNM;
  endfunction

  // one cycle: drive inputs at negedge, queue what outputs must be
  task automatic drive(input logic rst, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [15:0] sw, input logic rdy,
                       input logic we, input logic [AW-1:0] wa,
                       input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    reset = rst;
    mem_r = r;
    mem_w = w;
    M_addr = a;
    data_out = d;
    sw_in = sw;
    if (rst) begin
      m_d2c = '0;
      m_led = '0;
      m_err = 1'b0;
    end
    e.rdy = rdy;
    e.d2c = m_d2c;
    e.led = m_led;
    e.err = m_err;
    e.we = we;
    e.wa = wa;
    e.wd = wd;
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, $urandom, $urandom, 16'($urandom),
          1'b1, 1'b0, '0, '0);
  endtask

  // whole transaction; req held until and through the DONE cycle
  task automatic txn(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [15:0] sw,
                     output int low, output int wes,
                     output logic [31:0] ds, output logic [AW-1:0] was,
                     output logic [31:0] wds);
    kind_t k;
    int lat;
    int c0;
    logic rd;
    logic [31:0] rv;
    logic [AW-1:0] wi;
    k = classify(a);
    rd = r & ~w;
    lat = (k == K_RAM) ? 1 + LAT : 1;
    wi = a[AW+1:2];
    c0 = cyc;
    case (k)
      K_RAM: rv = mem_exp[wi];
      K_LED: rv = {16'h0, sw};
      K_TMR: rv = t_base + 32'(c0 - t_cyc);
      K_STS: rv = {31'h0, m_err};
      default: rv = '0;
    endcase
    low = 0;
    wes = 0;
    ds = '0;
    was = '0;
    wds = '0;
    for (int c = 0; c <= lat; c++) begin
      drive(1'b0, r, w, a, d, sw, c == lat,
            (k == K_RAM) && w && (c == 1), wi, d);
      if (c == 0) begin
        if (w && k == K_RAM) mem_exp[wi] = d;
        if (w && k == K_LED) m_led = d[15:0];
        if (w && k == K_TMR) begin
          t_base = d;
          t_cyc = c0 + 1;
        end
        if (w && k == K_STS) m_err = 1'b0;
`ifdef MIO_BUS_ERR_EN
        if (k == K_UNM) m_err = 1'b1;
`endif
      end
      if (c == lat - 1 && rd) m_d2c = rv;
      #1;
      if (!MIO_ready) low++;
      if (ram_we) begin
        wes++;
        was = ram_addr;
        wds = ram_din;
      end
      if (c == lat) ds = data2CPU;
    end
  endtask

  // compare DUT against queued expectations every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready", 32'(MIO_ready), 32'(e.rdy));
        chk("data2CPU", data2CPU, e.d2c);
        chk("led_out", 32'(led_out), 32'(e.led));
        chk("ram_we", 32'(ram_we), 32'(e.we));
        if (e.we) begin
          chk("ram_addr", 32'(ram_addr), 32'(e.wa));
          chk("ram_din", ram_din, e.wd);
        end
`ifdef MIO_BUS_ERR_EN
        chk("bus_err", 32'(bus_err), 32'(e.err));
`endif
      end
    end
  end

  initial begin
    int low;
    int wes;
    int sel;
    int rw;
    logic [31:0] ds;
    logic [31:0] wds;
    logic [31:0] a;
    logic [AW-1:0] was;

    for (int i = 0; i < (1 << AW); i++) mem_exp[i] = $urandom;
    mem_exp[4] = 32'h1234_5678;

    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
    t_base = '0;
    t_cyc = cyc;
    #1;
    chk("rst_ready", 32'(MIO_ready), 32'd1);
    chk("rst_data", data2CPU, 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);

    txn(1, 0, 32'hF000_0004, 0, 0, low, wes, ds, was, wds);
    chk("rst_timer", ds, 32'd0);

    txn(1, 0, 32'h0000_0010, 0, 0, low, wes, ds, was, wds);
    chk("ram_rd_data", ds, 32'h1234_5678);
    chk("ram_rd_low", 32'(low), 32'd4);

    txn(0, 1, 32'h0000_0010, 32'hCAFE_F00D, 0, low, wes, ds, was, wds);
    chk("ram_wr_low", 32'(low), 32'd4);
    chk("ram_wr_pulses", 32'(wes), 32'd1);
    chk("ram_wr_addr", 32'(was), 32'd4);
    chk("ram_wr_din", wds, 32'hCAFE_F00D);
    chk("ram_wr_done_rdy", 32'(MIO_ready), 32'd1);

    txn(1, 0, 32'h0000_0010, 0, 0, low, wes, ds, was, wds);
    chk("ram_rdback", ds, 32'hCAFE_F00D);

    txn(0, 1, 32'h0000_0FFC, 32'h0BAD_CAFE, 0, low, wes, ds, was, wds);
    txn(1, 0, 32'h0000_0FFC, 0, 0, low, wes, ds, was, wds);
    chk("ram_top_word", ds, 32'h0BAD_CAFE);
    txn(1, 0, 32'h0000_1000, 0, 0, low, wes, ds, was, wds);
    chk("past_ram_data", ds, 32'd0);
    chk("past_ram_low", 32'(low), 32'd1);

    txn(0, 1, 32'hF000_0000, 32'hFFFF_A5A5, 0, low, wes, ds, was, wds);
    chk("led_wr", 32'(led_out), 32'h0000_A5A5);
    chk("led_wr_low", 32'(low), 32'd1);
    txn(1, 0, 32'hF000_0000, 0, 16'h00FF, low, wes, ds, was, wds);
    chk("sw_rd", ds, 32'h0000_00FF);
    chk("sw_rd_low", 32'(low), 32'd1);
    txn(1, 1, 32'hF000_0000, 32'h1234_0F0F, 16'h5555,
        low, wes, ds, was, wds);
    chk("both_keep_data", ds, 32'h0000_00FF);
    chk("both_led", 32'(led_out), 32'h0000_0F0F);

    txn(0, 1, 32'hF000_0004, 32'hFFFF_FFFE, 0, low, wes, ds, was, wds);
    idle();
    txn(1, 0, 32'hF000_0004, 0, 0, low, wes, ds, was, wds);
    chk("timer_wrap", ds, 32'd0);

`ifdef MIO_BUS_ERR_EN
    txn(1, 0, 32'h8000_0000, 0, 0, low, wes, ds, was, wds);
    chk("unm_rd", ds, 32'd0);
    chk("unm_err", 32'(bus_err), 32'd1);
    txn(1, 0, 32'hF000_0008, 0, 0, low, wes, ds, was, wds);
    chk("sts_rd", ds, 32'd1);
    txn(0, 1, 32'hF000_0008, 0, 0, low, wes, ds, was, wds);
    chk("sts_clr", 32'(bus_err), 32'd0);
    txn(1, 0, 32'h0000_0002, 0, 0, low, wes, ds, was, wds);
    chk("misal_err", 32'(bus_err), 32'd1);
    chk("misal_low", 32'(low), 32'd1);
`endif

    // reset while a RAM write is in its wait state
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 0,
          1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 0,
          1'b0, 1'b0, '0, '0);
    #1;
    chk("abort_we", 32'(ram_we), 32'd0);
    chk("abort_ready", 32'(MIO_ready), 32'd0);
    chk("abort_data", data2CPU, 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
    t_base = '0;
    t_cyc = cyc;
    idle();
    txn(1, 0, 32'h0000_0020, 0, 0, low, wes, ds, was, wds);
    chk("abort_no_write", ds, mem_exp[8]);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0, 1: a = 32'($urandom_range(0, 4095));
        2: a = 32'hF000_0000 | 32'($urandom_range(0, 3));
        3: a = 32'hF000_0004 | 32'($urandom_range(0, 1));
        4: a = 32'hF000_0008;
        5: a = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
        default: a = {1'b1, 31'($urandom)};
      endcase
      rw = $urandom_range(0, 3);
      txn(rw != 1, rw == 1 || rw == 2, a, $urandom, 16'($urandom),
          low, wes, ds, was, wds);
      for (int g = 0; g < $urandom_range(0, 2); g++) idle();
    end

    idle();
    idle();
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
